// File: rtl/test_pattern_sequencer.sv
// Frame-synchronous test-pattern source for the HDMI transmitter: picks one of six
// patterns (auto-timed or push-button) and renders pixels two clocks after the raster counters.
module test_pattern_sequencer #(
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int DEBOUNCE_CYCLES    = 250000,
  parameter int BAR_WIDTH          = 92
) (
  input  logic       pixelClock,
  input  logic       resetN,
  input  logic       inActiveDisplay,
  input  logic [9:0] hPosCounter,
  input  logic [9:0] vPosCounter,
  input  logic       advanceButtonN,
  input  logic       autoCycleEnable,
  output logic [7:0] redByte,
  output logic [7:0] greenByte,
  output logic [7:0] blueByte,
  output logic [2:0] patternIndex,
  output logic       frameStart
);

  localparam int FW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN + 1) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_AUTO, S_MANUAL, S_PENDING} state_t;

  state_t        state, state_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [2:0]    pat, pat_n;
  logic          adv;
  logic          armed;
  logic          fb;
  logic          btn_s1, btn_s2, btn_deb;
  logic [DW-1:0] deb_cnt;
  logic          press;

  logic [9:0]    h_p1;
  logic          v5_p1;
  logic          vld_p1;
  logic          fs_p1;
  logic [2:0]    pat_p1;
  logic [23:0]   rgb_p2;
  logic [2:0]    pat_p2;
  logic          fs_p2;
  logic [2:0]    bar;
  logic [23:0]   colour;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      default: bar_colour = 24'h0000FF;
    endcase
  endfunction

  assign fb = (hPosCounter == 10'd0) && (vPosCounter == 10'd0);

  // Counter only runs while the synchronised level disagrees with the accepted one.
  assign press = btn_deb && !btn_s2 && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      btn_s1  <= 1'b1;
      btn_s2  <= 1'b1;
      btn_deb <= 1'b1;
      deb_cnt <= '0;
    end else begin
      btn_s1 <= advanceButtonN;
      btn_s2 <= btn_s1;
      if (btn_s2 != btn_deb) begin
        if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          btn_deb <= btn_s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    adv     = 1'b0;
    case (state)
      S_PENDING: begin
        if (fb) begin
          adv     = 1'b1;
          fcnt_n  = '0;
          state_n = autoCycleEnable ? S_AUTO : S_MANUAL;
        end
      end
      default: begin
        // A press landing exactly on fb is served by that boundary: one step only.
        if (press && fb) begin
          adv     = 1'b1;
          fcnt_n  = '0;
          state_n = autoCycleEnable ? S_AUTO : S_MANUAL;
        end else if (press) begin
          state_n = S_PENDING;
        end else if (state == S_MANUAL) begin
          fcnt_n = '0;
          if (autoCycleEnable) state_n = S_AUTO;
        end else if (!autoCycleEnable) begin
          fcnt_n  = '0;
          state_n = S_MANUAL;
        end else if (fb) begin
          if (fcnt == FW'(FRAMES_PER_PATTERN - 1)) begin
            adv    = 1'b1;
            fcnt_n = '0;
          end else begin
            fcnt_n = fcnt + FW'(1);
          end
        end
      end
    endcase
  end

  assign pat_n = adv ? ((pat == 3'd5) ? 3'd0 : pat + 3'd1) : pat;

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state <= S_AUTO;
      fcnt  <= '0;
      pat   <= 3'd0;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
      pat   <= pat_n;
      armed <= armed | fb;
    end
  end

  // Stage 1: sample raster position; output stays black until the first frame boundary.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      h_p1   <= '0;
      v5_p1  <= 1'b0;
      vld_p1 <= 1'b0;
      fs_p1  <= 1'b0;
      pat_p1 <= 3'd0;
    end else begin
      h_p1   <= hPosCounter;
      v5_p1  <= vPosCounter[5];
      vld_p1 <= inActiveDisplay & (armed | fb);
      fs_p1  <= fb;
      pat_p1 <= pat_n;
    end
  end

  always_comb begin
    bar = 3'd0;
    for (int k = 1; k <= 6; k++) begin
      if (int'(h_p1) >= k * BAR_WIDTH) bar = 3'(k);
    end
    colour = 24'h000000;
    if (vld_p1) begin
      case (pat_p1)
        3'd0:    colour = bar_colour(bar);
        3'd1:    colour = {h_p1[9:2], h_p1[9:2], h_p1[9:2]};
        3'd2:    colour = (h_p1[5] ^ v5_p1) ? 24'hFFFFFF : 24'h000000;
        3'd3:    colour = 24'hFF0000;
        3'd4:    colour = 24'h00FF00;
        3'd5:    colour = 24'h0000FF;
        default: colour = 24'h000000;
      endcase
    end
  end

  // Stage 2: registered colour with matching frame-start and pattern index.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      rgb_p2 <= '0;
      pat_p2 <= 3'd0;
      fs_p2  <= 1'b0;
    end else begin
      rgb_p2 <= colour;
      pat_p2 <= pat_p1;
      fs_p2  <= fs_p1;
    end
  end

  assign redByte      = rgb_p2[23:16];
  assign greenByte    = rgb_p2[15:8];
  assign blueByte     = rgb_p2[7:0];
  assign patternIndex = pat_p2;
  assign frameStart   = fs_p2;

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Randomised bench for test_pattern_sequencer: drives short synthetic frames and
// compares every output cycle against a frame-level reference model.
module tb_test_pattern_sequencer;

  localparam int FPP  = 2;
  localparam int DEB  = 4;
  localparam int BW   = 92;
  localparam int FLEN = 64;
  localparam int NF   = 40;

  localparam logic [23:0] BAR_TAB [7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF};

  typedef struct packed {
    logic [23:0] rgb;
    logic [2:0]  pat;
    logic        fs;
  } exp_t;

  logic       clk;
  logic       resetN;
  logic       act;
  logic [9:0] h_in;
  logic [9:0] v_in;
  logic       btn;
  logic       auto_en;
  logic [7:0] red, green, blue;
  logic [2:0] pat_idx;
  logic       frame_start;

  int checks;
  int errors;

  int m_pat, m_cnt;
  bit m_pending, m_armed;
  exp_t q[$];

  test_pattern_sequencer #(
    .FRAMES_PER_PATTERN(FPP),
    .DEBOUNCE_CYCLES(DEB),
    .BAR_WIDTH(BW)
  ) dut (
    .pixelClock(clk),
    .resetN(resetN),
    .inActiveDisplay(act),
    .hPosCounter(h_in),
    .vPosCounter(v_in),
    .advanceButtonN(btn),
    .autoCycleEnable(auto_en),
    .redByte(red),
    .greenByte(green),
    .blueByte(blue),
    .patternIndex(pat_idx),
    .frameStart(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] model_pix(input int pat, input int h, input int v, input bit a);
    int idx;
    int g;
    if (!a) return 24'h000000;
    case (pat)
      0: begin
        idx = h / BW;
        if (idx > 6) idx = 6;
        return BAR_TAB[idx];
      end
      1: begin
        g = (h / 4) % 256;
        return {8'(g), 8'(g), 8'(g)};
      end
      2: return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      3: return 24'hFF0000;
      4: return 24'h00FF00;
      5: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  initial begin
    int p1s, p1l, p2s, p2l;
    int dh [8];
    int dv [8];
    exp_t e;
    logic [23:0] rgb;
    bit fb;

    dh = '{0, 92, 91, 600, 400, 32, 32, 552};
    dv = '{1, 1, 1, 1, 1, 0, 32, 1};
    checks = 0; errors = 0;
    resetN = 1'b0; btn = 1'b1; auto_en = 1'b1; act = 1'b1; h_in = 10'd100; v_in = 10'd10;
    m_pat = 0; m_cnt = 0; m_pending = 0; m_armed = 0;

    repeat (5) begin
      @(negedge clk);
      check_eq("reset_rgb", {8'h0, red, green, blue}, 32'h0);
      check_eq("reset_pat", {29'h0, pat_idx}, 32'h0);
      check_eq("reset_fs", {31'h0, frame_start}, 32'h0);
    end
    @(posedge clk); #1 resetN = 1'b1;

    for (int f = 0; f < NF; f++) begin
      p1s = -1; p1l = 0; p2s = -1; p2l = 0;
      case (f)
        15: begin p1s = 10; p1l = 10; end
        18: begin p1s = 10; p1l = 3; end
        19: begin p1s = 10; p1l = 10; end
        20: begin p1s = 5; p1l = 10; p2s = 40; p2l = 10; end
        21: begin p1s = 30; p1l = 2; end
        default: begin
          if (f >= 27 && $urandom_range(0, 1) == 1) begin
            p1s = $urandom_range(2, 20);
            p1l = $urandom_range(2, 12);
            if ($urandom_range(0, 2) == 0) begin
              p2s = $urandom_range(40, 44);
              p2l = $urandom_range(2, 12);
            end
          end
        end
      endcase

      for (int c = 0; c < FLEN; c++) begin
        @(posedge clk); #1;
        resetN = !(f == 14 && c >= 20 && c < 25);
        if (c == 1) begin
          if (f < 18) auto_en = 1'b1;
          else if (f < 27) auto_en = 1'b0;
          else auto_en = ($urandom_range(0, 3) != 0);
        end
        btn = !((c >= p1s && c < p1s + p1l && p1s >= 0) || (c >= p2s && c < p2s + p2l && p2s >= 0));
        if (c == 0) begin
          h_in = 10'd0; v_in = 10'd0; act = 1'b1;
        end else if (c <= 8) begin
          h_in = 10'(dh[c-1]); v_in = 10'(dv[c-1]); act = 1'b1;
        end else begin
          h_in = 10'($urandom_range(0, 1023));
          v_in = 10'($urandom_range(1, 1023));
          act  = ($urandom_range(0, 3) != 0);
        end
        fb = (c == 0);

        if (!resetN) begin
          m_pat = 0; m_cnt = 0; m_pending = 0; m_armed = 0;
          e = '0;
        end else begin
          if ((c == p1s && p1l >= DEB) || (c == p2s && p2l >= DEB)) m_pending = 1;
          if (fb) begin
            if (m_pending) begin
              m_pat = (m_pat + 1) % 6; m_cnt = 0; m_pending = 0;
            end else if (auto_en) begin
              if (m_cnt == FPP - 1) begin
                m_pat = (m_pat + 1) % 6; m_cnt = 0;
              end else begin
                m_cnt++;
              end
            end else begin
              m_cnt = 0;
            end
            m_armed = 1;
          end
          e.rgb = m_armed ? model_pix(m_pat, int'(h_in), int'(v_in), act) : 24'h000000;
          e.pat = 3'(m_pat);
          e.fs  = fb;
        end
        q.push_back(e);

        @(negedge clk);
        if (q.size() > 2) begin
          e = q.pop_front();
          if (!resetN) e = '0;
          rgb = {red, green, blue};
          check_eq($sformatf("rgb f%0d c%0d", f, c), {8'h0, rgb}, {8'h0, e.rgb});
          check_eq($sformatf("pat f%0d c%0d", f, c), {29'h0, pat_idx}, {29'h0, e.pat});
          check_eq($sformatf("fs f%0d c%0d", f, c), {31'h0, frame_start}, {31'h0, e.fs});
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
